// File: rtl/pcpi_mon_pkg.sv
// pcpi_mon_pkg
//   Shared definitions for the PCPI protocol monitor:
//   - error code width and the six error code constants
//   - FSM state encoding (IDLE / ACTIVE / DONE)
//   - first_err_code(): picks the lowest active code from an error vector
package pcpi_mon_pkg;

  localparam int ERR_CODE_W = 3;

  typedef logic [ERR_CODE_W-1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 3'd0;
  localparam err_code_t ERR_SANITY  = 3'd1;
  localparam err_code_t ERR_EARLY   = 3'd2;
  localparam err_code_t ERR_LATE    = 3'd3;
  localparam err_code_t ERR_TIMEOUT = 3'd4;
  localparam err_code_t ERR_CLASS   = 3'd5;
  localparam err_code_t ERR_ABORT   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } mon_state_e;

  // Bit i of err_vec stands for error code i+1. When several errors fire in
  // the same cycle the lowest code is the one reported.
  function automatic err_code_t first_err_code(input logic [5:0] err_vec);
    err_code_t code;
    code = ERR_NONE;
    for (int i = 5; i >= 0; i--) begin
      if (err_vec[i]) code = err_code_t'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/pcpi_mon_stats.sv
// pcpi_mon_stats
//   Saturating transaction statistics for the PCPI protocol monitor.
//   Only instantiated when PCPI_MON_STATS_EN is defined.
// Ports
//   clk, resetn  clock, async active-low reset
//   done_i       one-cycle strobe: a transaction completed (ready in ACTIVE)
//   lat_i        start-to-ready latency of that transaction
//   insn_count   number of completed transactions, saturates at all-ones
//   max_lat      largest latency seen since reset
module pcpi_mon_stats
  import pcpi_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             done_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic [CNT_W-1:0] insn_count,
  output logic [CNT_W-1:0] max_lat
);

  logic [CNT_W-1:0] insn_count_q, insn_count_d;
  logic [CNT_W-1:0] max_lat_q, max_lat_d;

  // max_lat can never exceed the all-ones value, so only the count needs
  // an explicit saturation guard.
  always_comb begin
    insn_count_d = insn_count_q;
    max_lat_d    = max_lat_q;
    if (done_i) begin
      if (insn_count_q != '1) insn_count_d = insn_count_q + CNT_W'(1);
      if (lat_i > max_lat_q)  max_lat_d    = lat_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      insn_count_q <= '0;
      max_lat_q    <= '0;
    end else begin
      insn_count_q <= insn_count_d;
      max_lat_q    <= max_lat_d;
    end
  end

  assign insn_count = insn_count_q;
  assign max_lat    = max_lat_q;

endmodule

// File: rtl/pcpi_protocol_monitor.sv
// pcpi_protocol_monitor
//   Passive PCPI handshake and latency checker. Taps the CPU<->coprocessor
//   PCPI wires, tracks each request through IDLE/ACTIVE/DONE, checks the
//   per-class expected latency and a timeout, and captures the first error
//   (code + cycle stamp) until cleared.
// Configuration macro
//   PCPI_MON_STATS_EN  when defined, insn_count/max_lat come from the
//                      pcpi_mon_stats sub-module; otherwise both are 0.
// Ports
//   clk, resetn               clock, async active-low reset
//   pcpi_valid/wait/ready/wr  tapped PCPI handshake
//   insn_class                one-hot class of the insn, sampled at start
//   exp_lat                   per-class expected latency fields (0 = unchecked)
//   err_clr                   synchronous clear of the sticky error state
//   err_flag                  sticky error indicator
//   err_pulse                 one-cycle strobe for every detected error
//   err_code                  code of the first captured error
//   err_cycle                 cycle stamp of the first captured error
//   busy                      transaction in flight (ACTIVE)
//   insn_count, max_lat       statistics (PCPI_MON_STATS_EN only)
module pcpi_protocol_monitor
  import pcpi_mon_pkg::*;
#(
  parameter int NUM_CLASSES = 7,
  parameter int LAT_W       = 4,
  parameter int MAX_WAIT    = 64,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         pcpi_valid,
  input  logic                         pcpi_wait,
  input  logic                         pcpi_ready,
  input  logic                         pcpi_wr,
  input  logic [NUM_CLASSES-1:0]       insn_class,
  input  logic [NUM_CLASSES*LAT_W-1:0] exp_lat,
  input  logic                         err_clr,
  output logic                         err_flag,
  output logic                         err_pulse,
  output logic [ERR_CODE_W-1:0]        err_code,
  output logic [CNT_W-1:0]             err_cycle,
  output logic                         busy,
  output logic [CNT_W-1:0]             insn_count,
  output logic [CNT_W-1:0]             max_lat
);

  // Latency counter must reach MAX_WAIT; MAX_WAIT >= 2^LAT_W keeps it at
  // least as wide as a latency field.
  localparam int CW = $clog2(MAX_WAIT + 1);

  mon_state_e       state_q, state_d;
  logic             last_valid_q, last_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             err_flag_q, err_flag_d;
  logic             err_pulse_q, err_pulse_d;
  err_code_t        err_code_q, err_code_d;
  logic [CNT_W-1:0] err_cycle_q, err_cycle_d;
  logic             busy_q, busy_d;

  logic [LAT_W-1:0] sel_lat;
  logic [LAT_W-1:0] start_lat;
  logic             class_ok;
  logic             start;
  logic             e_sanity, e_early, e_late, e_timeout, e_class, e_abort;
  logic [5:0]       err_vec;
  logic             flag_kept;

  assign last_valid_d = pcpi_valid;
  assign cyc_d        = cyc_q + CNT_W'(1);

  // OR of the fields of all set class bits; equals the selected field when
  // insn_class is one-hot, and is discarded otherwise.
  always_comb begin
    sel_lat = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (insn_class[i]) sel_lat = sel_lat | exp_lat[i*LAT_W +: LAT_W];
    end
  end

  assign class_ok  = (insn_class != '0) &&
                     ((insn_class & (insn_class - NUM_CLASSES'(1))) == '0);
  assign start_lat = class_ok ? sel_lat : '0;
  assign start     = (state_q == ST_IDLE) && pcpi_valid && !last_valid_q;

  // Transaction FSM plus the per-cycle protocol checks. cnt_q holds the
  // cycle index relative to the start cycle (start = 0) while ACTIVE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    e_sanity  = (pcpi_valid && !pcpi_wait && !pcpi_ready) ||
                (pcpi_valid && (pcpi_ready != pcpi_wr)) ||
                (!pcpi_valid && (pcpi_wait || pcpi_ready || pcpi_wr));
    e_early   = 1'b0;
    e_late    = 1'b0;
    e_timeout = 1'b0;
    e_class   = 1'b0;
    e_abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          e_class = !class_ok;
          lat_d   = start_lat;
          // Ready in the start cycle completes the insn without leaving IDLE.
          if (pcpi_ready) begin
            e_early = (start_lat != '0);
          end else begin
            state_d = ST_ACTIVE;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (pcpi_ready) begin
          state_d = ST_DONE;
          e_early = (lat_q != '0) && (cnt_q < CW'(lat_q));
        end else begin
          e_late = (lat_q != '0) && (cnt_q == CW'(lat_q));
          if (!pcpi_valid) begin
            e_abort = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_q == CW'(MAX_WAIT)) begin
            e_timeout = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        // The CPU must drop valid in the cycle after ready.
        if (pcpi_valid) e_sanity = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_vec = {e_abort, e_class, e_timeout, e_late, e_early, e_sanity};
  assign busy_d  = (state_d == ST_ACTIVE);

  // Sticky capture: a clear in the same cycle as a new error re-arms the
  // capture first, so the new error is recorded and the flag stays set.
  always_comb begin
    flag_kept   = err_flag_q && !err_clr;
    err_pulse_d = |err_vec;
    err_flag_d  = flag_kept || (|err_vec);
    err_code_d  = err_clr ? ERR_NONE : err_code_q;
    err_cycle_d = err_clr ? '0 : err_cycle_q;
    if ((|err_vec) && !flag_kept) begin
      err_code_d  = first_err_code(err_vec);
      err_cycle_d = cyc_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_valid_q <= 1'b0;
      cnt_q        <= '0;
      lat_q        <= '0;
      cyc_q        <= '0;
      err_flag_q   <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_cycle_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_valid_q <= last_valid_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      cyc_q        <= cyc_d;
      err_flag_q   <= err_flag_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      err_cycle_q  <= err_cycle_d;
      busy_q       <= busy_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_cycle = err_cycle_q;
  assign busy      = busy_q;

`ifdef PCPI_MON_STATS_EN
  logic done_evt;

  // Only completions from ACTIVE are counted; cnt_q is the latency then.
  assign done_evt = (state_q == ST_ACTIVE) && pcpi_ready;

  pcpi_mon_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .resetn    (resetn),
    .done_i    (done_evt),
    .lat_i     (CNT_W'(cnt_q)),
    .insn_count(insn_count),
    .max_lat   (max_lat)
  );
`else
  assign insn_count = '0;
  assign max_lat    = '0;
`endif

endmodule

// File: tb/tb_pcpi_protocol_monitor.sv
// tb_pcpi_protocol_monitor
//   Table of per-cycle PCPI vectors with the outputs expected after each
//   clock edge. Each applied vector pushes its expectation to a scoreboard
//   queue that is popped and compared once the edge has registered it.
//   Hand-written parts cover reset state, statistics and mid-insn reset.
module tb_pcpi_protocol_monitor;

  localparam int NUM_CLASSES = 7;
  localparam int LAT_W       = 4;
  localparam int MAX_WAIT    = 64;
  localparam int CNT_W       = 32;

`ifdef PCPI_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic       H    = 1'b1;
  localparam logic       L    = 1'b0;
  localparam logic [2:0] DC   = 3'd7;
  localparam logic [6:0] C0   = 7'b0000001;
  localparam logic [6:0] C3   = 7'b0001000;
  localparam logic [6:0] C4   = 7'b0010000;
  localparam logic [6:0] C5   = 7'b0100000;
  localparam logic [6:0] CBAD = 7'b0000110;
  localparam logic [6:0] CN   = 7'b0000000;

  logic                         clk = 1'b0;
  logic                         resetn;
  logic                         pcpi_valid, pcpi_wait, pcpi_ready, pcpi_wr;
  logic [NUM_CLASSES-1:0]       insn_class;
  logic [NUM_CLASSES*LAT_W-1:0] exp_lat;
  logic                         err_clr;
  logic                         err_flag, err_pulse, busy;
  logic [2:0]                   err_code;
  logic [CNT_W-1:0]             err_cycle, insn_count, max_lat;

  typedef struct {
    logic       v;
    logic       wt;
    logic       r;
    logic       wr;
    logic [6:0] cls;
    logic       clr;
    logic       ep;
    logic       ef;
    logic [2:0] ec;
    logic       eb;
    logic       cc;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  int          seg_end[4];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] tb_cyc;

  always #5 clk = ~clk;

  // Edges since reset release; the DUT stamp at edge k is tb_cyc-1 after it.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_cyc <= '0;
    else         tb_cyc <= tb_cyc + 32'd1;
  end

  pcpi_protocol_monitor #(
    .NUM_CLASSES(NUM_CLASSES),
    .LAT_W      (LAT_W),
    .MAX_WAIT   (MAX_WAIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pcpi_valid(pcpi_valid),
    .pcpi_wait (pcpi_wait),
    .pcpi_ready(pcpi_ready),
    .pcpi_wr   (pcpi_wr),
    .insn_class(insn_class),
    .exp_lat   (exp_lat),
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_cycle (err_cycle),
    .busy      (busy),
    .insn_count(insn_count),
    .max_lat   (max_lat)
  );

  function automatic void add(input logic v, wt, r, wr, input logic [6:0] cls,
                              input logic clr, ep, ef, input logic [2:0] ec,
                              input logic eb, cc);
    vec_t x;
    x.v = v; x.wt = wt; x.r = r; x.wr = wr; x.cls = cls; x.clr = clr;
    x.ep = ep; x.ef = ef; x.ec = ec; x.eb = eb; x.cc = cc;
    tbl.push_back(x);
  endfunction

  task automatic cmp(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s idx=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t x);
    @(negedge clk);
    pcpi_valid = x.v;
    pcpi_wait  = x.wt;
    pcpi_ready = x.r;
    pcpi_wr    = x.wr;
    insn_class = x.cls;
    err_clr    = x.clr;
    sb.push_back(x);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty idx=%0d actual=0 expected=1", idx);
    end else begin
      e = sb.pop_front();
      cmp("err_pulse", idx, 32'(err_pulse), 32'(e.ep));
      cmp("err_flag",  idx, 32'(err_flag),  32'(e.ef));
      cmp("busy",      idx, 32'(busy),      32'(e.eb));
      if (e.ec != DC) cmp("err_code", idx, 32'(err_code), 32'(e.ec));
      if (e.cc)       cmp("err_cycle", idx, err_cycle, tb_cyc - 32'd1);
    end
  endtask

  task automatic checkResetState(input int idx);
    cmp("rst_err_flag",   idx, 32'(err_flag),  32'd0);
    cmp("rst_err_pulse",  idx, 32'(err_pulse), 32'd0);
    cmp("rst_err_code",   idx, 32'(err_code),  32'd0);
    cmp("rst_err_cycle",  idx, err_cycle,      32'd0);
    cmp("rst_busy",       idx, 32'(busy),      32'd0);
    cmp("rst_insn_count", idx, insn_count,     32'd0);
    cmp("rst_max_lat",    idx, max_lat,        32'd0);
  endtask

  task automatic checkStats(input int idx, input int cnt, input int lat);
    cmp("insn_count", idx, insn_count, STATS ? 32'(cnt) : 32'd0);
    cmp("max_lat",    idx, max_lat,    STATS ? 32'(lat) : 32'd0);
  endtask

  task automatic runSeg(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(i);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog idx=-1 actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Vector fields: valid wait ready wr class clr | pulse flag code busy stamp
    // Class 0 lat 1: clean single-wait insn.
    add(H,H,L,L,C0,L, L,L,3'd0,H,L);
    add(H,L,H,H,C0,L, L,L,3'd0,L,L);
    add(L,L,L,L,CN,L, L,L,3'd0,L,L);
    seg_end[0] = tbl.size();
    // Class 3 lat 6, ready at cycle 4 -> EARLY; then a clean insn keeps code.
    add(H,H,L,L,C3,L, L,L,3'd0,H,L);
    for (int i = 0; i < 3; i++) add(H,H,L,L,C3,L, L,L,3'd0,H,L);
    add(H,L,H,H,C3,L, H,H,3'd2,L,H);
    add(L,L,L,L,CN,L, L,H,3'd2,L,L);
    add(H,H,L,L,C0,L, L,H,3'd2,H,L);
    add(H,L,H,H,C0,L, L,H,3'd2,L,L);
    add(L,L,L,L,CN,L, L,H,3'd2,L,L);
    // Clear, then unchecked class held in wait until TIMEOUT at cnt 64.
    add(L,L,L,L,CN,H, L,L,DC,L,L);
    add(H,H,L,L,C4,L, L,L,DC,H,L);
    for (int i = 1; i < MAX_WAIT; i++) add(H,H,L,L,C4,L, L,L,DC,H,L);
    add(H,H,L,L,C4,L, H,H,3'd4,L,H);
    add(L,L,L,L,CN,H, L,L,DC,L,L);
    // Ready in the start cycle with lat 2 -> EARLY; then ready!=wr with clear.
    add(H,L,H,H,C5,L, H,H,3'd2,L,L);
    add(L,L,L,L,CN,L, L,H,3'd2,L,L);
    add(H,L,H,L,C4,H, H,H,3'd1,L,H);
    add(L,L,L,L,CN,L, L,H,3'd1,L,L);
    // Clear, non-one-hot class -> CLASS; later insn aborted mid-wait.
    add(L,L,L,L,CN,H, L,L,DC,L,L);
    add(H,H,L,L,CBAD,L, H,H,3'd5,H,L);
    add(H,H,L,L,CBAD,L, L,H,3'd5,H,L);
    add(H,H,L,L,CBAD,L, L,H,3'd5,H,L);
    add(H,L,H,H,CBAD,L, L,H,3'd5,L,L);
    add(L,L,L,L,CN,L, L,H,3'd5,L,L);
    add(H,H,L,L,C3,L, L,H,3'd5,H,L);
    add(H,H,L,L,C3,L, L,H,3'd5,H,L);
    add(L,L,L,L,CN,L, H,H,3'd5,L,L);
    add(L,L,L,L,CN,L, L,H,3'd5,L,L);
    // Clear, class 0 lat 1 with no ready at cnt 1 -> LATE, keeps waiting.
    add(L,L,L,L,CN,H, L,L,DC,L,L);
    add(H,H,L,L,C0,L, L,L,DC,H,L);
    add(H,H,L,L,C0,L, H,H,3'd3,H,L);
    add(H,H,L,L,C0,L, L,H,3'd3,H,L);
    add(H,L,H,H,C0,L, L,H,3'd3,L,L);
    add(L,L,L,L,CN,L, L,H,3'd3,L,L);
    seg_end[1] = tbl.size();
    // Class 3 lat 6 insn interrupted by reset at cnt 3.
    for (int i = 0; i < 3; i++) add(H,H,L,L,C3,L, L,H,3'd3,H,L);
    seg_end[2] = tbl.size();
    // Valid held across reset release: fresh start, ready at cycle 6.
    add(H,H,L,L,C3,L, L,L,3'd0,H,L);
    for (int i = 0; i < 5; i++) add(H,H,L,L,C3,L, L,L,3'd0,H,L);
    add(H,L,H,H,C3,L, L,L,3'd0,L,L);
    add(L,L,L,L,CN,L, L,L,3'd0,L,L);
    seg_end[3] = tbl.size();

    exp_lat    = {4'd0, 4'd2, 4'd0, 4'd6, 4'd0, 4'd0, 4'd1};
    resetn     = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    insn_class = '0;
    err_clr    = 1'b0;
    #1 resetn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState(-1);
    @(posedge clk);
    #2 resetn = 1'b1;

    runSeg(0, seg_end[0]);
    checkStats(-10, 1, 1);
    runSeg(seg_end[0], seg_end[1]);
    checkStats(-11, 5, 4);
    runSeg(seg_end[1], seg_end[2]);

    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkResetState(-2);
    @(posedge clk);
    #2 resetn = 1'b1;
    runSeg(seg_end[2], seg_end[3]);
    checkStats(-12, 1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
